// File: rtl/sha2_pkg.sv
// sha2_pkg: shared SHA-512 schedule constants, state encoding and rotate helper.
package sha2_pkg;
    localparam int DATA_WIDTH  = 64;
    localparam int ROUNDS      = 80;
    localparam int BLOCK_WORDS = 16;
    localparam int IDX_WIDTH   = 7;
    localparam int S0_ROT_A    = 1;
    localparam int S0_ROT_B    = 8;
    localparam int S0_SHR      = 7;
    localparam int S1_ROT_A    = 19;
    localparam int S1_ROT_B    = 61;
    localparam int S1_SHR      = 6;
    typedef logic [DATA_WIDTH-1:0] word_t;
    typedef logic [IDX_WIDTH-1:0] idx_t;
    typedef enum logic {LOAD, EXPAND} state_e;
    function automatic word_t rotr(input word_t x, input int n);
        return (x >> n) | (x << (DATA_WIDTH - n));
    endfunction
endpackage

// File: rtl/sha512_msg_schedule_if.sv
// sha512_msg_schedule_if: message-word input stream and round-word output stream.
interface sha512_msg_schedule_if;
    import sha2_pkg::*;
    word_t in_word;
    logic  in_valid;
    logic  in_ready;
    word_t out_word;
    idx_t  out_index;
    logic  out_last;
    logic  out_valid;
    logic  out_ready;
    logic  busy;
    modport master (
        output in_word, in_valid, out_ready,
        input  in_ready, out_word, out_index, out_last, out_valid, busy
    );
    modport slave (
        input  in_word, in_valid, out_ready,
        output in_ready, out_word, out_index, out_last, out_valid, busy
    );
endinterface

// File: rtl/small_sigma.sv
// small_sigma: SHA-512 small sigma, ROTR(ROT_A) ^ ROTR(ROT_B) ^ SHR(SHR).
module small_sigma import sha2_pkg::*; #(
    parameter int ROT_A = 1,
    parameter int ROT_B = 8,
    parameter int SHR   = 7
) (
    input  word_t x_i,
    output word_t y_o
);
    assign y_o = rotr(x_i, ROT_A) ^ rotr(x_i, ROT_B) ^ (x_i >> SHR);
endmodule

// File: rtl/sha512_msg_schedule.sv
// sha512_msg_schedule: expands a 16-word SHA-512 block into round words W_0..W_79,
// one per cycle on a valid/ready stream with a single output register stage.
module sha512_msg_schedule import sha2_pkg::*; (
    input logic clk,
    input logic reset,
    sha512_msg_schedule_if.slave bus
);
    state_e state_q, state_d;
    idx_t t_q, t_d;
    logic [BLOCK_WORDS-1:0][DATA_WIDTH-1:0] win_q, win_d;
    word_t out_word_q, out_word_d;
    idx_t out_index_q, out_index_d;
    logic out_last_q, out_last_d;
    logic out_valid_q, out_valid_d;
    logic en, take, step, last_t;
    word_t sig0, sig1, sum_a, car_a, sum_b, car_b, w_exp, w_new;

    small_sigma #(.ROT_A(S0_ROT_A), .ROT_B(S0_ROT_B), .SHR(S0_SHR)) u_sig0 (.x_i(win_q[1]), .y_o(sig0));
    small_sigma #(.ROT_A(S1_ROT_A), .ROT_B(S1_ROT_B), .SHR(S1_SHR)) u_sig1 (.x_i(win_q[14]), .y_o(sig1));

    // Two 3:2 compressors reduce the four addends so only one carry-propagate adder remains.
    always_comb begin
        sum_a = sig1 ^ win_q[9] ^ sig0;
        car_a = ((sig1 & win_q[9]) | (sig1 & sig0) | (win_q[9] & sig0)) << 1;
        sum_b = sum_a ^ car_a ^ win_q[0];
        car_b = ((sum_a & car_a) | (sum_a & win_q[0]) | (car_a & win_q[0])) << 1;
        w_exp = sum_b + car_b;
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= LOAD;
        else state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (state_q == LOAD && take && t_q == idx_t'(BLOCK_WORDS - 1)) state_d = EXPAND;
        else if (state_q == EXPAND && step && last_t) state_d = LOAD;
    end

    always_comb begin
        en = !out_valid_q || bus.out_ready;
        bus.in_ready = !reset && state_q == LOAD && en;
        bus.busy = state_q == EXPAND || t_q != '0;
        take = bus.in_valid && bus.in_ready;
        step = state_q == EXPAND && en;
        last_t = t_q == idx_t'(ROUNDS - 1);
    end

    always_comb begin
        w_new = state_q == LOAD ? bus.in_word : w_exp;
        win_d = win_q;
        t_d = t_q;
        out_word_d = out_word_q;
        out_index_d = out_index_q;
        out_last_d = out_last_q;
        out_valid_d = out_valid_q;
        if (take || step) begin
            win_d = {w_new, win_q[BLOCK_WORDS-1:1]};
            t_d = last_t ? '0 : t_q + idx_t'(1);
            out_word_d = w_new;
            out_index_d = t_q;
            out_last_d = last_t;
            out_valid_d = 1'b1;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            t_q <= '0;
            win_q <= '0;
            out_word_q <= '0;
            out_index_q <= '0;
            out_last_q <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            t_q <= t_d;
            win_q <= win_d;
            out_word_q <= out_word_d;
            out_index_q <= out_index_d;
            out_last_q <= out_last_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.out_word = out_word_q;
    assign bus.out_index = out_index_q;
    assign bus.out_last = out_last_q;
    assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_sha512_msg_schedule.sv
// tb_sha512_msg_schedule: scoreboard bench; a reference schedule model queues every
// expected round word when a block is driven and a negedge monitor pops on handshake.
module tb_sha512_msg_schedule;
    import sha2_pkg::*;

    typedef struct packed {
        word_t word;
        idx_t  idx;
        logic  last;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int passes = 0;
    int active = 0;
    bit rnd_ready = 1'b0;
    exp_t sb[$];
    word_t obs_word[ROUNDS];
    word_t blk[BLOCK_WORDS];
    word_t blk2[BLOCK_WORDS];
    exp_t mon_cur, mon_exp, mon_held;
    bit mon_stall = 1'b0;

    sha512_msg_schedule_if bus();
    sha512_msg_schedule dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    function automatic word_t rs0(input word_t x);
        return {x[0], x[63:1]} ^ {x[7:0], x[63:8]} ^ (x >> 7);
    endfunction

    function automatic word_t rs1(input word_t x);
        return {x[18:0], x[63:19]} ^ {x[60:0], x[63:61]} ^ (x >> 6);
    endfunction

    task automatic push_model(input word_t m[BLOCK_WORDS]);
        word_t w[ROUNDS];
        for (int t = 0; t < ROUNDS; t++) begin
            if (t < BLOCK_WORDS) w[t] = m[t];
            else w[t] = rs1(w[t-2]) + w[t-7] + rs0(w[t-15]) + w[t-16];
            sb.push_back('{w[t], idx_t'(t), t == ROUNDS - 1});
        end
    endtask

    task automatic clear_obs();
        for (int i = 0; i < ROUNDS; i++) obs_word[i] = '0;
    endtask

    task automatic load_abc();
        for (int i = 0; i < BLOCK_WORDS; i++) blk[i] = '0;
        blk[0] = 64'h6162638000000000;
        blk[15] = 64'h18;
    endtask

    task automatic send_block(input word_t m[BLOCK_WORDS], input bit rnd_valid);
        int i = 0;
        int g = 0;
        bit hs;
        active++;
        while (i < BLOCK_WORDS && g < 3000) begin
            bus.in_valid = rnd_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.in_word = m[i];
            @(negedge clk);
            hs = bus.in_valid && bus.in_ready;
            @(posedge clk);
            #1;
            if (hs) i++;
            g++;
        end
        bus.in_valid = 1'b0;
        checks++;
        if (i != BLOCK_WORDS) $display("FAIL send_timeout: accepted %0d words, expected %0d", i, BLOCK_WORDS);
        else passes++;
        active--;
    endtask

    task automatic wait_drain();
        int g = 0;
        while ((sb.size() != 0 || active != 0) && g < 6000) begin
            @(negedge clk);
            g++;
        end
        checks++;
        if (sb.size() != 0) $display("FAIL drain_timeout: %0d words pending, expected 0", sb.size());
        else passes++;
        @(posedge clk);
        #1;
    endtask

    // Negedge monitor: scoreboard pop, stall hold and in_ready blocking.
    initial begin
        forever begin
            @(negedge clk);
            mon_cur = '{bus.out_word, bus.out_index, bus.out_last};
            if (reset) begin
                mon_stall = 1'b0;
            end else begin
                if (mon_stall) begin
                    checks++;
                    if (mon_cur !== mon_held || bus.out_valid !== 1'b1)
                        $display("FAIL stall_hold: got %h/%0d/%b valid %b, expected %h/%0d/%b valid 1",
                                 mon_cur.word, mon_cur.idx, mon_cur.last, bus.out_valid,
                                 mon_held.word, mon_held.idx, mon_held.last);
                    else passes++;
                end
                if (bus.out_valid && (!bus.out_ready || (bus.out_index >= 15 && bus.out_index <= 78))) begin
                    checks++;
                    if (bus.in_ready !== 1'b0)
                        $display("FAIL in_ready_blocked: in_ready %b at index %0d out_ready %b, expected 0",
                                 bus.in_ready, bus.out_index, bus.out_ready);
                    else passes++;
                end
                if (bus.out_valid && bus.out_ready) begin
                    checks++;
                    if (sb.size() == 0) begin
                        $display("FAIL unexpected_output: got index %0d word %h, expected no output",
                                 bus.out_index, bus.out_word);
                    end else begin
                        mon_exp = sb.pop_front();
                        if (mon_cur !== mon_exp)
                            $display("FAIL sb_word: got %h/%0d/%b, expected %h/%0d/%b",
                                     mon_cur.word, mon_cur.idx, mon_cur.last,
                                     mon_exp.word, mon_exp.idx, mon_exp.last);
                        else passes++;
                    end
                    if (bus.out_index < ROUNDS) obs_word[bus.out_index] = bus.out_word;
                end
                mon_stall = bus.out_valid && !bus.out_ready;
                mon_held = mon_cur;
            end
        end
    end

    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic test_reset();
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.out_valid, bus.out_word, bus.out_index, bus.out_last, bus.busy, bus.in_ready} !== '0)
            $display("FAIL reset_values: got valid %b word %h index %0d last %b busy %b in_ready %b, expected all 0",
                     bus.out_valid, bus.out_word, bus.out_index, bus.out_last, bus.busy, bus.in_ready);
        else passes++;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1) $display("FAIL ready_after_reset: got %b, expected 1", bus.in_ready);
        else passes++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_abc();
        int g = 0;
        int vc = 0;
        int lc = 0;
        clear_obs();
        load_abc();
        push_model(blk);
        fork
            send_block(blk, 1'b0);
        join_none
        do begin
            @(negedge clk);
            g++;
        end while (!bus.out_valid && g < 50);
        for (int k = 0; k < ROUNDS; k++) begin
            if (k > 0) @(negedge clk);
            if (bus.out_valid) vc++;
            if (bus.out_valid && bus.out_last) begin
                lc++;
                checks++;
                if (bus.out_index !== 7'd79) $display("FAIL abc_last_index: got %0d, expected 79", bus.out_index);
                else passes++;
            end
        end
        checks++;
        if (vc != ROUNDS) $display("FAIL abc_valid_run: got %0d consecutive valid cycles, expected 80", vc);
        else passes++;
        checks++;
        if (lc != 1) $display("FAIL abc_last_count: got %0d, expected 1", lc);
        else passes++;
        wait_drain();
        for (int i = 0; i < BLOCK_WORDS; i++) begin
            checks++;
            if (obs_word[i] !== blk[i]) $display("FAIL abc_echo: W_%0d got %h, expected %h", i, obs_word[i], blk[i]);
            else passes++;
        end
        checks++;
        if (obs_word[16] !== 64'h6162638000000000) $display("FAIL abc_w16: got %h, expected 6162638000000000", obs_word[16]);
        else passes++;
        checks++;
        if (obs_word[17] !== 64'h00030000000000C0) $display("FAIL abc_w17: got %h, expected 00030000000000c0", obs_word[17]);
        else passes++;
    endtask

    task automatic test_ones();
        clear_obs();
        for (int i = 0; i < BLOCK_WORDS; i++) blk[i] = '1;
        push_model(blk);
        send_block(blk, 1'b0);
        wait_drain();
        checks++;
        if (obs_word[16] !== 64'h05FFFFFFFFFFFFFC) $display("FAIL ones_w16: got %h, expected 05fffffffffffffc", obs_word[16]);
        else passes++;
    endtask

    task automatic test_back_to_back();
        int g = 0;
        for (int i = 0; i < BLOCK_WORDS; i++) begin
            blk[i] = {$urandom, $urandom};
            blk2[i] = {$urandom, $urandom};
        end
        push_model(blk);
        push_model(blk2);
        fork
            begin
                send_block(blk, 1'b0);
                send_block(blk2, 1'b0);
            end
        join_none
        do begin
            @(negedge clk);
            g++;
        end while (!(bus.out_valid && bus.out_last) && g < 400);
        checks++;
        if (!(bus.out_valid && bus.out_last)) $display("FAIL b2b_first_last: no W_79 within %0d cycles, expected one", g);
        else passes++;
        @(negedge clk);
        checks++;
        if ({bus.out_valid, bus.out_index, bus.out_word} !== {1'b1, 7'd0, blk2[0]})
            $display("FAIL b2b_next_m0: got valid %b index %0d word %h, expected valid 1 index 0 word %h",
                     bus.out_valid, bus.out_index, bus.out_word, blk2[0]);
        else passes++;
        wait_drain();
    endtask

    task automatic test_random();
        rnd_ready = 1'b1;
        for (int b = 0; b < 20; b++) begin
            for (int i = 0; i < BLOCK_WORDS; i++) blk[i] = {$urandom, $urandom};
            push_model(blk);
            send_block(blk, 1'b1);
        end
        wait_drain();
        rnd_ready = 1'b0;
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset_mid();
        int g = 0;
        for (int i = 0; i < BLOCK_WORDS; i++) blk[i] = {$urandom, $urandom};
        push_model(blk);
        fork
            send_block(blk, 1'b0);
        join_none
        do begin
            @(negedge clk);
            g++;
        end while (!(bus.out_valid && bus.out_index == 7'd40) && g < 200);
        checks++;
        if (!(bus.out_valid && bus.out_index == 7'd40)) $display("FAIL mid_reach40: got index %0d, expected 40", bus.out_index);
        else passes++;
        @(posedge clk);
        #1;
        reset = 1'b1;
        sb.delete();
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.out_valid, bus.busy, bus.out_index} !== '0)
            $display("FAIL mid_reset_state: got valid %b busy %b index %0d, expected 0 0 0",
                     bus.out_valid, bus.busy, bus.out_index);
        else passes++;
        @(posedge clk);
        #1;
        reset = 1'b0;
        clear_obs();
        load_abc();
        push_model(blk);
        fork
            send_block(blk, 1'b0);
        join_none
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (!bus.out_valid && g < 50);
        checks++;
        if ({bus.out_valid, bus.out_index, bus.out_word} !== {1'b1, 7'd0, blk[0]})
            $display("FAIL mid_first_out: got valid %b index %0d word %h, expected valid 1 index 0 word %h",
                     bus.out_valid, bus.out_index, bus.out_word, blk[0]);
        else passes++;
        wait_drain();
        checks++;
        if (obs_word[16] !== 64'h6162638000000000) $display("FAIL mid_w16: got %h, expected 6162638000000000", obs_word[16]);
        else passes++;
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_word = '0;
        test_reset();
        test_abc();
        test_ones();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
